instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded instruction requests over a valid/ready
// handshake, packs them into 32-bit MIPS-style words, and streams them into an
// instruction memory at consecutive word addresses.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  // Word count at which the memory is completely filled.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [0:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              hs;

  // Ops 10..15 have no encoding.
  function automatic logic op_ok(input logic [3:0] o);
    return o <= 4'd9;
  endfunction

  // Pack the fields for the selected format; fields a format does not use are dropped.
  function automatic logic [31:0] encode(input logic [3:0]  o,
                                         input logic [4:0]  s,
                                         input logic [4:0]  t,
                                         input logic [4:0]  d,
                                         input logic [15:0] i,
                                         input logic [25:0] tg);
    logic [31:0] w;
    w = 32'h0;
    case (o)
      4'd0:    w = {6'h00, s, t, d, 5'b0, 6'h20};
      4'd1:    w = {6'h00, s, t, d, 5'b0, 6'h22};
      4'd2:    w = {6'h00, s, t, d, 5'b0, 6'h24};
      4'd3:    w = {6'h00, s, t, d, 5'b0, 6'h25};
      4'd4:    w = {6'h00, s, t, d, 5'b0, 6'h2A};
      4'd5:    w = {6'h23, s, t, i};
      4'd6:    w = {6'h2B, s, t, i};
      4'd7:    w = {6'h04, s, t, i};
      4'd8:    w = {6'h05, s, t, i};
      4'd9:    w = {6'h02, tg};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign in_ready = (state == IDLE) && !full;
  assign hs       = in_valid && in_ready;

  // Handshake/write FSM: an accepted request is registered onto the memory port
  // and strobed for one cycle; the pointer and count advance as the strobe ends.
  // Clear beats both a new request and the post-write increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            err    <= 1'b0;
          end else if (hs) begin
            if (op_ok(op)) begin
              state      <= WRITE;
              imem_we    <= 1'b1;
              imem_addr  <= wr_ptr;
              imem_wdata <= encode(op, rs, rt, rd, imm, target);
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          // The strobe has been presented for this cycle; the write completes here.
          state   <= IDLE;
          imem_we <= 1'b0;
          if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            err    <= 1'b0;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
            full   <= ((count + 1'b1) == DEPTH);
          end
        end
        default: begin
          state   <= IDLE;
          imem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
